// File: rtl/apu_pkg.sv
// Shared APU constants and types for the noise channel register block.
// Read masks, length limit and length-counter state encoding.
package apu_pkg;

  localparam logic [7:0] NR41_RMASK = 8'hFF;
  localparam logic [7:0] NR44_RMASK = 8'hBF;
  localparam logic [5:0] LEN_MAX    = 6'd63;

  typedef logic [5:0] len_t;

  typedef enum logic {
    LEN_COUNTING,
    LEN_EXPIRED
  } len_state_e;

endpackage

// File: rtl/ch4_regs_if.sv
// CPU strobe/select bundle for the noise channel registers.
// The 8-bit data bus stays a plain tristate port on the block.
interface ch4_regs_if;

  logic ncpu_wr;
  logic ncpu_rd;
  logic ff20;
  logic ff21;
  logic ff22;
  logic ff23;

  modport master (
    output ncpu_wr, ncpu_rd,
    output ff20, ff21, ff22, ff23
  );

  modport slave (
    input ncpu_wr, ncpu_rd,
    input ff20, ff21, ff22, ff23
  );

endinterface

// File: rtl/ch4_length_counter.sv
// Noise channel 6-bit length counter with expiry state.
// Load and trigger restart leave the expired state.
module ch4_length_counter
  import apu_pkg::*;
(
  input  logic nphi,
  input  logic apu_reset,
  input  logic load,
  input  len_t load_val,
  input  logic restart,
  input  logic tick,
  output len_t len_cnt,
  output logic fugo_q
);

  len_state_e state_q;
  len_state_e state_d;
  len_t       cnt_d;

  always_ff @(posedge nphi or posedge apu_reset) begin
    if (apu_reset) begin
      state_q <= LEN_COUNTING;
      len_cnt <= '0;
    end else begin
      state_q <= state_d;
      len_cnt <= cnt_d;
    end
  end

  // A load swallows any coincident tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = len_cnt;
    if (load) begin
      cnt_d   = load_val;
      state_d = LEN_COUNTING;
    end else begin
      if (state_q == LEN_COUNTING && tick) begin
        if (len_cnt == LEN_MAX) begin
          cnt_d   = '0;
          state_d = LEN_EXPIRED;
        end else begin
          cnt_d = len_cnt + 6'd1;
        end
      end
      if (restart) begin
        state_d = LEN_COUNTING;
      end
    end
  end

  assign fugo_q = (state_q == LEN_EXPIRED);

endmodule

// File: rtl/ch4_regs.sv
// Noise channel CPU register block (NR41-NR44, FF20-FF23).
// CH4_LEN_READBACK_EN: FF20 read returns {2'b11, len_cnt}.
module ch4_regs
  import apu_pkg::*;
#(
  parameter logic [7:0] NR42_RST = 8'h00,
  parameter logic [7:0] NR43_RST = 8'h00
) (
  input  logic       nphi,
  input  logic       apu_reset,
  inout  wire  [7:0] d,
  ch4_regs_if.slave  bus,
  input  logic       len_tick,
  input  logic       rst_ff23_d7,
  output logic [7:0] ff21_q,
  output logic [7:0] ff22_q,
  output logic       ff23_d6,
  output logic       ff23_d7,
  output logic       fugo_q,
  output len_t       len_cnt
);

  logic       wr;
  logic       rd;
  logic       wr20;
  logic       wr23;
  logic       any_sel;
  logic [7:0] rdata;
  logic [7:0] ff20_rd;

  assign wr   = ~bus.ncpu_wr;
  assign rd   = ~bus.ncpu_rd;
  assign wr20 = wr & bus.ff20;
  assign wr23 = wr & bus.ff23;

  assign any_sel = bus.ff20 | bus.ff21
                 | bus.ff22 | bus.ff23;

  always_ff @(posedge nphi or posedge apu_reset) begin
    if (apu_reset) begin
      ff21_q  <= NR42_RST;
      ff22_q  <= NR43_RST;
      ff23_d6 <= 1'b0;
      ff23_d7 <= 1'b0;
    end else begin
      if (wr & bus.ff21) ff21_q <= d;
      if (wr & bus.ff22) ff22_q <= d;
      if (wr23) ff23_d6 <= d[6];
      // A CPU trigger write beats the channel's clear.
      if (wr23) begin
        ff23_d7 <= d[7];
      end else if (!rst_ff23_d7) begin
        ff23_d7 <= 1'b0;
      end
    end
  end

  ch4_length_counter u_len (
    .nphi      (nphi),
    .apu_reset (apu_reset),
    .load      (wr20),
    .load_val  (d[5:0]),
    .restart   (wr23 & d[7]),
    .tick      (len_tick & ff23_d6),
    .len_cnt   (len_cnt),
    .fugo_q    (fugo_q)
  );

`ifdef CH4_LEN_READBACK_EN
  assign ff20_rd = {2'b11, len_cnt};
`else
  assign ff20_rd = NR41_RMASK;
`endif

  always_comb begin
    rdata = 8'hFF;
    unique case (1'b1)
      bus.ff20: rdata = ff20_rd;
      bus.ff21: rdata = ff21_q;
      bus.ff22: rdata = ff22_q;
      bus.ff23: rdata = NR44_RMASK
                      | {1'b0, ff23_d6, 6'b0};
      default:  rdata = 8'hFF;
    endcase
  end

  assign d = (rd & any_sel) ? rdata : 8'hzz;

endmodule

// File: tb/tb_ch4_regs.sv
// Directed self-checking bench for the noise channel register block.
// Expected values are hand-computed per scenario.
module tb_ch4_regs;

  logic       nphi = 1'b0;
  logic       apu_reset;
  wire  [7:0] d;
  logic [7:0] d_drv;
  logic       d_en;
  logic       len_tick;
  logic       rst_ff23_d7;
  logic [7:0] ff21_q;
  logic [7:0] ff22_q;
  logic       ff23_d6;
  logic       ff23_d7;
  logic       fugo_q;
  logic [5:0] len_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  ch4_regs_if bus ();

  assign d = d_en ? d_drv : 8'hzz;

  for (genvar i = 0; i < 8; i++) begin : g_pd
    pulldown (d[i]);
  end

  ch4_regs dut (
    .nphi        (nphi),
    .apu_reset   (apu_reset),
    .d           (d),
    .bus         (bus.slave),
    .len_tick    (len_tick),
    .rst_ff23_d7 (rst_ff23_d7),
    .ff21_q      (ff21_q),
    .ff22_q      (ff22_q),
    .ff23_d6     (ff23_d6),
    .ff23_d7     (ff23_d7),
    .fugo_q      (fugo_q),
    .len_cnt     (len_cnt)
  );

  always #5 nphi = ~nphi;

  task automatic set_sel(input int s);
    bus.ff20 = (s == 0);
    bus.ff21 = (s == 1);
    bus.ff22 = (s == 2);
    bus.ff23 = (s == 3);
  endtask

  task automatic idle();
    set_sel(-1);
    bus.ncpu_wr = 1'b1;
    bus.ncpu_rd = 1'b1;
    d_en        = 1'b0;
    d_drv       = 8'h00;
    len_tick    = 1'b0;
    rst_ff23_d7 = 1'b1;
  endtask

  task automatic setup_wr(input int s,
                          input logic [7:0] v);
    set_sel(s);
    bus.ncpu_wr = 1'b0;
    d_en        = 1'b1;
    d_drv       = v;
  endtask

  task automatic wr(input int s,
                    input logic [7:0] v);
    @(negedge nphi);
    setup_wr(s, v);
    @(negedge nphi);
    idle();
  endtask

  task automatic rd(input int s,
                    output logic [7:0] v);
    @(negedge nphi);
    set_sel(s);
    bus.ncpu_rd = 1'b0;
    #1 v = d;
    idle();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge nphi);
      len_tick = 1'b1;
      @(negedge nphi);
      len_tick = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    logic [7:0] exp20;
    idle();
    apu_reset = 1'b1;
    repeat (2) @(negedge nphi);
    apu_reset = 1'b0;
    n_cmp++;
    if ({ff21_q, ff22_q} !== 16'h0000) begin
      n_bad++;
      $display("FAIL rst_regs got %h want 0000",
               {ff21_q, ff22_q});
    end
    n_cmp++;
    if ({ff23_d6, ff23_d7, fugo_q, len_cnt}
        !== 9'h000) begin
      n_bad++;
      $display("FAIL rst_len got %b want 0",
               {ff23_d6, ff23_d7, fugo_q, len_cnt});
    end
    rd(3, v);
    n_cmp++;
    if (v !== 8'hBF) begin
      n_bad++;
      $display("FAIL rst_rd23 got %h want bf", v);
    end
    @(negedge nphi);
    set_sel(3);
    #1 v = d;
    idle();
    n_cmp++;
    if (v !== 8'h00) begin
      n_bad++;
      $display("FAIL rst_hiz got %h want 00", v);
    end
`ifdef CH4_LEN_READBACK_EN
    exp20 = 8'hC0;
`else
    exp20 = 8'hFF;
`endif
    rd(0, v);
    n_cmp++;
    if (v !== exp20) begin
      n_bad++;
      $display("FAIL rst_rd20 got %h want %h",
               v, exp20);
    end
  endtask

  task automatic test_regs();
    logic [7:0] v;
    @(negedge nphi);
    setup_wr(2, 8'h5A);
    #1;
    n_cmp++;
    if (ff22_q !== 8'h00) begin
      n_bad++;
      $display("FAIL ff22_early got %h want 00",
               ff22_q);
    end
    @(negedge nphi);
    idle();
    n_cmp++;
    if (ff22_q !== 8'h5A) begin
      n_bad++;
      $display("FAIL ff22_q got %h want 5a", ff22_q);
    end
    @(negedge nphi);
    setup_wr(1, 8'hF3);
    #1;
    n_cmp++;
    if (ff21_q !== 8'h00) begin
      n_bad++;
      $display("FAIL ff21_early got %h want 00",
               ff21_q);
    end
    @(negedge nphi);
    idle();
    n_cmp++;
    if (ff21_q !== 8'hF3) begin
      n_bad++;
      $display("FAIL ff21_q got %h want f3", ff21_q);
    end
    rd(2, v);
    n_cmp++;
    if (v !== 8'h5A) begin
      n_bad++;
      $display("FAIL rd22 got %h want 5a", v);
    end
    rd(1, v);
    n_cmp++;
    if (v !== 8'hF3) begin
      n_bad++;
      $display("FAIL rd21 got %h want f3", v);
    end
  endtask

  task automatic test_trigger();
    logic [7:0] v;
    wr(3, 8'hC0);
    n_cmp++;
    if ({ff23_d7, ff23_d6} !== 2'b11) begin
      n_bad++;
      $display("FAIL trig_set got %b want 11",
               {ff23_d7, ff23_d6});
    end
    rd(3, v);
    n_cmp++;
    if (v !== 8'hFF) begin
      n_bad++;
      $display("FAIL rd23_d6 got %h want ff", v);
    end
    @(negedge nphi);
    rst_ff23_d7 = 1'b0;
    @(negedge nphi);
    rst_ff23_d7 = 1'b1;
    n_cmp++;
    if ({ff23_d7, ff23_d6} !== 2'b01) begin
      n_bad++;
      $display("FAIL trig_clr got %b want 01",
               {ff23_d7, ff23_d6});
    end
    @(negedge nphi);
    setup_wr(3, 8'hC0);
    rst_ff23_d7 = 1'b0;
    @(negedge nphi);
    idle();
    n_cmp++;
    if (ff23_d7 !== 1'b1) begin
      n_bad++;
      $display("FAIL trig_race got %b want 1",
               ff23_d7);
    end
    @(negedge nphi);
    rst_ff23_d7 = 1'b0;
    @(negedge nphi);
    rst_ff23_d7 = 1'b1;
    n_cmp++;
    if (ff23_d7 !== 1'b0) begin
      n_bad++;
      $display("FAIL trig_clr2 got %b want 0",
               ff23_d7);
    end
  endtask

  task automatic test_length();
    wr(0, 8'h3E);
    wr(3, 8'h40);
    n_cmp++;
    if ({fugo_q, len_cnt} !== {1'b0, 6'h3E}) begin
      n_bad++;
      $display("FAIL len_load got %b_%h want 0_3e",
               fugo_q, len_cnt);
    end
    ticks(1);
    n_cmp++;
    if ({fugo_q, len_cnt} !== {1'b0, 6'h3F}) begin
      n_bad++;
      $display("FAIL len_3f got %b_%h want 0_3f",
               fugo_q, len_cnt);
    end
    ticks(1);
    n_cmp++;
    if ({fugo_q, len_cnt} !== {1'b1, 6'h00}) begin
      n_bad++;
      $display("FAIL len_wrap got %b_%h want 1_00",
               fugo_q, len_cnt);
    end
    ticks(1);
    n_cmp++;
    if ({fugo_q, len_cnt} !== {1'b1, 6'h00}) begin
      n_bad++;
      $display("FAIL len_hold got %b_%h want 1_00",
               fugo_q, len_cnt);
    end
  endtask

  task automatic test_recovery();
    wr(3, 8'hC0);
    n_cmp++;
    if ({fugo_q, len_cnt} !== {1'b0, 6'h00}) begin
      n_bad++;
      $display("FAIL rec_trig got %b_%h want 0_00",
               fugo_q, len_cnt);
    end
    ticks(63);
    n_cmp++;
    if ({fugo_q, len_cnt} !== {1'b0, 6'h3F}) begin
      n_bad++;
      $display("FAIL rec_63 got %b_%h want 0_3f",
               fugo_q, len_cnt);
    end
    ticks(1);
    n_cmp++;
    if ({fugo_q, len_cnt} !== {1'b1, 6'h00}) begin
      n_bad++;
      $display("FAIL rec_64 got %b_%h want 1_00",
               fugo_q, len_cnt);
    end
    @(negedge nphi);
    setup_wr(0, 8'hC5);
    len_tick = 1'b1;
    @(negedge nphi);
    idle();
    n_cmp++;
    if ({fugo_q, len_cnt} !== {1'b0, 6'h05}) begin
      n_bad++;
      $display("FAIL ld_tick got %b_%h want 0_05",
               fugo_q, len_cnt);
    end
    @(negedge nphi);
    setup_wr(3, 8'h00);
    len_tick = 1'b1;
    @(negedge nphi);
    idle();
    n_cmp++;
    if ({ff23_d6, len_cnt} !== {1'b0, 6'h06}) begin
      n_bad++;
      $display("FAIL old_d6 got %b_%h want 0_06",
               ff23_d6, len_cnt);
    end
    ticks(3);
    n_cmp++;
    if ({fugo_q, len_cnt} !== {1'b0, 6'h06}) begin
      n_bad++;
      $display("FAIL frozen got %b_%h want 0_06",
               fugo_q, len_cnt);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] v;
    logic [7:0] exp20;
    wr(0, 8'h14);
    wr(3, 8'hC0);
    n_cmp++;
    if ({ff23_d7, len_cnt} !== {1'b1, 6'h14}) begin
      n_bad++;
      $display("FAIL pre_rst got %b_%h want 1_14",
               ff23_d7, len_cnt);
    end
`ifdef CH4_LEN_READBACK_EN
    exp20 = 8'hD4;
`else
    exp20 = 8'hFF;
`endif
    rd(0, v);
    n_cmp++;
    if (v !== exp20) begin
      n_bad++;
      $display("FAIL rd20_len got %h want %h",
               v, exp20);
    end
    @(negedge nphi);
    #2 apu_reset = 1'b1;
    #1;
    n_cmp++;
    if ({ff23_d7, ff23_d6, len_cnt, ff22_q}
        !== 16'h0000) begin
      n_bad++;
      $display("FAIL async_clr got %h want 0000",
               {ff23_d7, ff23_d6, len_cnt, ff22_q});
    end
    @(negedge nphi);
    setup_wr(2, 8'h77);
    @(negedge nphi);
    idle();
    n_cmp++;
    if (ff22_q !== 8'h00) begin
      n_bad++;
      $display("FAIL wr_in_rst got %h want 00",
               ff22_q);
    end
    apu_reset = 1'b0;
  endtask

  initial begin
    apu_reset = 1'b1;
    idle();
    test_reset();
    test_regs();
    test_trigger();
    test_length();
    test_recovery();
    test_async_reset();
    repeat (2) @(negedge nphi);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
